// File: rtl/wave_pkg.sv
// wave_pkg: constants and encodings shared by the wave-RAM writer
// (wave_capture_ctrl) and the LCD waveform reader (lcd_display).
//   WAVE_DEPTH : points per frame, equal to the display's column count
//   WAVE_AW    : wave RAM address width
//   TRIG_RISE / TRIG_FALL : trig_edge encodings
//   wave_state_e : capture FSM states
package wave_pkg;

  localparam int WAVE_DEPTH = 300;
  localparam int WAVE_AW    = 9;

  localparam logic TRIG_RISE = 1'b0;
  localparam logic TRIG_FALL = 1'b1;

  typedef enum logic [1:0] {
    PRE_FILL = 2'd0,
    ARMED    = 2'd1,
    POST     = 2'd2,
    HOLD     = 2'd3
  } wave_state_e;

endpackage

// File: rtl/wave_capture_ctrl_trig_detect.sv
// trig_detect: edge detector for the wave capture trigger.
// Holds the previous strobed sample and compares it and the current
// strobed sample against the trigger level.
//   clk, rst_n  : AD clock, synchronous active-low reset
//   strobe      : decimator sample strobe; prev only advances on strobes
//   sample      : current AD sample
//   level       : trigger level
//   edge_sel    : TRIG_RISE / TRIG_FALL
//   trig_hit    : combinational, high on the strobe whose sample crosses
module trig_detect
  import wave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic [7:0] sample,
  input  logic [7:0] level,
  input  logic       edge_sel,
  output logic       trig_hit
);

  logic [7:0] prev_q, prev_d;

  // prev follows every strobe regardless of capture state, so the first
  // compare after re-arming uses real history rather than a stale value.
  always_comb begin
    prev_d = prev_q;
    if (strobe) prev_d = sample;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= prev_d;
  end

  always_comb begin
    trig_hit = 1'b0;
    if (strobe) begin
      if (edge_sel == TRIG_RISE) trig_hit = (prev_q < level) && (sample >= level);
      else                       trig_hit = (prev_q > level) && (sample <= level);
    end
  end

endmodule

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: writer side of the LCD wave RAM (AD clock domain).
// Writes decimated samples into a DEPTH-point circular buffer, keeps
// PRE_TRIG samples of history before the trigger, freezes a full frame and
// re-arms when the display reports the frame has been drawn.
//   ad_clk, rst_n          : clock, synchronous active-low reset
//   ad_data, deci_en       : sample and decimator strobe
//   trig_level, trig_edge  : trigger level and edge select
//   wr_over                : frame-drawn pulse from the LCD domain
//   ram_wr_en/addr/data    : wave RAM write port (1-cycle latency)
//   frame_base             : RAM address of display column 0
//   frame_valid            : a complete frame is frozen
//   trig_found             : 1 = real trigger, 0 = auto timeout
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int DEPTH    = WAVE_DEPTH,
  parameter int PRE_TRIG = 150,
  parameter int AUTO_TO  = 4096,
  parameter int AW       = WAVE_AW
) (
  input  logic          ad_clk,
  input  logic          rst_n,
  input  logic [7:0]    ad_data,
  input  logic          deci_en,
  input  logic [7:0]    trig_level,
  input  logic          trig_edge,
  input  logic          wr_over,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [7:0]    ram_wr_data,
  output logic [AW-1:0] frame_base,
  output logic          frame_valid,
  output logic          trig_found
);

  localparam int CW  = $clog2(((DEPTH > AUTO_TO) ? DEPTH : AUTO_TO) + 1);
  localparam int AW1 = AW + 1;
  localparam logic [CW-1:0] PRE_CNT   = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_CNT  = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] TO_CNT    = CW'(AUTO_TO);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X   = AW1'(DEPTH);
  localparam logic [AW:0]   PRE_X     = AW1'(PRE_TRIG);

  // Oldest frame address: (t - PRE_TRIG) mod DEPTH, adding DEPTH first when
  // t is below PRE_TRIG so the intermediate never goes negative.
  function automatic logic [AW-1:0] base_of(input logic [AW-1:0] t);
    logic [AW:0] tx;
    tx = {1'b0, t};
    if (tx >= PRE_X) return AW'(tx - PRE_X);
    else             return AW'(tx + DEPTH_X - PRE_X);
  endfunction

  wave_state_e   state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, wptr_inc;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [AW-1:0] t_addr_q, t_addr_d;
  logic          trig_real_q, trig_real_d;
  logic          ram_wr_en_q, ram_wr_en_d;
  logic [AW-1:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [7:0]    ram_wr_data_q, ram_wr_data_d;
  logic [AW-1:0] frame_base_q, frame_base_d;
  logic          frame_valid_q, frame_valid_d;
  logic          trig_found_q, trig_found_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic          ovr_p;
  logic          trig_hit;

  trig_detect u_trig (
    .clk      (ad_clk),
    .rst_n    (rst_n),
    .strobe   (deci_en),
    .sample   (ad_data),
    .level    (trig_level),
    .edge_sel (trig_edge),
    .trig_hit (trig_hit)
  );

  // wr_over comes from lcd_pclk: two flops to resynchronise, a third to
  // find its rising edge so a long pulse re-arms only once.
  assign ovr_p = sync2_q & ~sync3_q;

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    cnt_d         = cnt_q;
    t_addr_d      = t_addr_q;
    trig_real_d   = trig_real_q;
    ram_wr_en_d   = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    frame_base_d  = frame_base_q;
    frame_valid_d = frame_valid_q;
    trig_found_d  = trig_found_q;
    cnt_inc       = cnt_q + 1'b1;
    wptr_inc      = (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;

    if (state_q != HOLD && deci_en) begin
      ram_wr_en_d   = 1'b1;
      ram_wr_addr_d = wptr_q;
      ram_wr_data_d = ad_data;
      wptr_d        = wptr_inc;
    end

    case (state_q)
      PRE_FILL: begin
        if (deci_en) begin
          if (cnt_inc == PRE_CNT) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ARMED: begin
        // A real trigger takes precedence over a simultaneous timeout.
        if (deci_en) begin
          if (trig_hit || cnt_inc == TO_CNT) begin
            state_d     = POST;
            cnt_d       = '0;
            t_addr_d    = wptr_q;
            trig_real_d = trig_hit;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      POST: begin
        if (deci_en) begin
          if (cnt_inc == POST_CNT) begin
            state_d       = HOLD;
            cnt_d         = '0;
            frame_valid_d = 1'b1;
            frame_base_d  = base_of(t_addr_q);
            trig_found_d  = trig_real_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (ovr_p) begin
          state_d       = PRE_FILL;
          cnt_d         = '0;
          frame_valid_d = 1'b0;
        end
      end
      default: state_d = PRE_FILL;
    endcase
  end

  always_ff @(posedge ad_clk) begin
    if (!rst_n) begin
      state_q       <= PRE_FILL;
      wptr_q        <= '0;
      cnt_q         <= '0;
      t_addr_q      <= '0;
      trig_real_q   <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      frame_base_q  <= '0;
      frame_valid_q <= 1'b0;
      trig_found_q  <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      cnt_q         <= cnt_d;
      t_addr_q      <= t_addr_d;
      trig_real_q   <= trig_real_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      frame_base_q  <= frame_base_d;
      frame_valid_q <= frame_valid_d;
      trig_found_q  <= trig_found_d;
      sync1_q       <= wr_over;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
    end
  end

  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign frame_base  = frame_base_q;
  assign frame_valid = frame_valid_q;
  assign trig_found  = trig_found_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
`timescale 1ns/100ps
module tb_wave_capture_ctrl;

  localparam int DEPTH    = 300;
  localparam int PRE_TRIG = 150;
  localparam int AUTO_TO  = 16;
  localparam int AW       = 9;

  logic          ad_clk = 1'b0;
  logic          rst_n;
  logic [7:0]    ad_data;
  logic          deci_en;
  logic [7:0]    trig_level;
  logic          trig_edge;
  logic          wr_over;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [7:0]    ram_wr_data;
  logic [AW-1:0] frame_base;
  logic          frame_valid;
  logic          trig_found;

  always #5 ad_clk = ~ad_clk;

  wave_capture_ctrl #(
    .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .AUTO_TO(AUTO_TO), .AW(AW)
  ) dut (
    .ad_clk      (ad_clk),
    .rst_n       (rst_n),
    .ad_data     (ad_data),
    .deci_en     (deci_en),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .wr_over     (wr_over),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .frame_base  (frame_base),
    .frame_valid (frame_valid),
    .trig_found  (trig_found)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // wr_over as seen by the DUT at each rising ad_clk edge
  logic wo_smp = 1'b0;
  always @(posedge ad_clk) wo_smp <= wr_over;

  // Frame-level reference: counts strobes since (re)start, locates the
  // trigger index from the crossing / timeout rules, and freezes when the
  // frame holds DEPTH samples.
  int  m_ptr, m_n, m_tidx, m_tptr, m_base, m_prev;
  bit  m_real, m_hold, m_valid, m_found;
  bit  w1, w2, w3;
  bit  e_en;
  int  e_addr, e_data;
  logic [7:0] shadow [DEPTH];

  task automatic model_reset();
    m_ptr = 0; m_n = 0; m_tidx = -1; m_tptr = 0; m_base = 0; m_prev = 0;
    m_real = 0; m_hold = 0; m_valid = 0; m_found = 0;
    w1 = 0; w2 = 0; w3 = 0;
    e_en = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step(input bit rstv, input bit d, input int x, input int lvl,
                            input bit edg, input bit wo);
    bit ovr, hit;
    int i;
    e_en = 0;
    if (!rstv) begin
      model_reset();
      return;
    end
    ovr = w2 && !w3;
    w3 = w2; w2 = w1; w1 = wo;
    hit = edg ? (m_prev > lvl && x <= lvl) : (m_prev < lvl && x >= lvl);
    if (m_hold) begin
      if (ovr) begin
        m_hold = 0; m_valid = 0; m_n = 0; m_tidx = -1;
      end
    end else if (d) begin
      e_en = 1; e_addr = m_ptr; e_data = x;
      m_ptr = (m_ptr + 1) % DEPTH;
      i = m_n;
      m_n++;
      if (m_tidx < 0 && i >= PRE_TRIG && (hit || (i - PRE_TRIG + 1) == AUTO_TO)) begin
        m_tidx = i; m_real = hit; m_tptr = e_addr;
      end
      if (m_tidx >= 0 && m_n == m_tidx + DEPTH - PRE_TRIG) begin
        m_hold = 1; m_valid = 1; m_found = m_real;
        m_base = (m_tptr - PRE_TRIG + DEPTH) % DEPTH;
      end
    end
    if (d) m_prev = x;
  endtask

  task automatic cycle(input bit rstv, input bit d, input logic [7:0] x,
                       input logic [7:0] lvl, input bit edg);
    rst_n = rstv; deci_en = d; ad_data = x; trig_level = lvl; trig_edge = edg;
    @(posedge ad_clk);
    #1;
    model_step(rstv, d, int'(x), int'(lvl), edg, wo_smp);
    chk("wr_en", ram_wr_en, e_en);
    if (e_en) begin
      chk("wr_addr", ram_wr_addr, e_addr);
      chk("wr_data", ram_wr_data, e_data);
    end
    chk("frame_valid", frame_valid, m_valid);
    chk("frame_base", frame_base, m_base);
    chk("trig_found", trig_found, m_found);
    if (ram_wr_en === 1'b1 && int'(ram_wr_addr) < DEPTH) shadow[ram_wr_addr] = ram_wr_data;
  endtask

  task automatic rearm();
    wr_over = 1'b1;
    repeat (3) cycle(1, 0, 8'd0, 8'd128, 1'b0);
    wr_over = 1'b0;
    for (int k = 0; k < 8 && frame_valid; k++) cycle(1, 0, 8'd0, 8'd128, 1'b0);
    chk("rearm_valid_low", frame_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, post_w, idx, cnt, fall, rises, hold_wr, p0, n;
    logic [7:0] x, lvl;
    bit edg, prev_v;

    rst_n = 1'b0; deci_en = 1'b0; ad_data = '0; trig_level = 8'd128;
    trig_edge = 1'b0; wr_over = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) shadow[i] = 8'hxx;
    repeat (3) cycle(0, 0, 8'd0, 8'd128, 1'b0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_wr_addr", ram_wr_addr, 0);
    chk("rst_wr_data", ram_wr_data, 0);
    chk("rst_base", frame_base, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_found", trig_found, 0);

    // Ramp starting at 229: the 128 crossing lands on strobe 155.
    s = 0; post_w = -1;
    for (int k = 0; k < 400 && !frame_valid; k++) begin
      cycle(1, 1, 8'((229 + s) % 256), 8'd128, 1'b0);
      s++;
      if (post_w >= 0 && ram_wr_en) post_w++;
      if (post_w < 0 && ram_wr_en && ram_wr_addr == 155) post_w = 0;
    end
    chk("t1_valid", frame_valid, 1);
    chk("t1_found", trig_found, 1);
    chk("t1_base", frame_base, 5);
    chk("t1_post_writes", post_w, 149);
    idx = (int'(frame_base) + PRE_TRIG) % DEPTH;
    chk("t1_trig_word", shadow[idx], 128);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 8'((229 + s) % 256), 8'd128, 1'b0);
      s++;
    end

    // Asynchronous 5-cycle lcd_pclk wr_over pulse while in HOLD.
    fall = -1; rises = 0; hold_wr = 0; prev_v = frame_valid;
    fork
      begin
        #3.3;
        wr_over = 1'b1;
        #65;
        wr_over = 1'b0;
      end
      begin
        for (int k = 0; k < 14; k++) begin
          cycle(1, 1, 8'd77, 8'd128, 1'b0);
          if (frame_valid && ram_wr_en) hold_wr++;
          if (!frame_valid && fall < 0) fall = k;
          if (frame_valid && !prev_v) rises++;
          prev_v = frame_valid;
        end
      end
    join
    chk("t4_fall_seen", (fall >= 0 && fall <= 3), 1);
    chk("t4_no_refreeze", rises, 0);
    chk("t4_hold_writes", hold_wr, 0);

    // Falling trigger on the single 50 sample; wr_over pulsed during POST.
    n = 0;
    for (int k = 0; k < 400 && !frame_valid; k++) begin
      if (n == 153 + 20) wr_over = 1'b1;
      if (n == 153 + 23) wr_over = 1'b0;
      cycle(1, 1, (n == 153) ? 8'd50 : 8'd200, 8'd128, 1'b1);
      n++;
    end
    wr_over = 1'b0;
    chk("t2_valid", frame_valid, 1);
    chk("t2_found", trig_found, 1);
    idx = (int'(frame_base) + PRE_TRIG) % DEPTH;
    chk("t2_trig_word", shadow[idx], 50);
    cnt = 0;
    for (int j = 0; j < PRE_TRIG; j++)
      if (shadow[(int'(frame_base) + j) % DEPTH] === 8'd200) cnt++;
    chk("t2_pre_words", cnt, PRE_TRIG);
    cnt = 0;
    for (int j = PRE_TRIG + 1; j < DEPTH; j++)
      if (shadow[(int'(frame_base) + j) % DEPTH] === 8'd200) cnt++;
    chk("t2_post_words", cnt, DEPTH - PRE_TRIG - 1);
    repeat (10) cycle(1, 1, 8'd200, 8'd128, 1'b1);
    chk("t5_valid_kept", frame_valid, 1);
    rearm();

    // Constant input never crosses: forced trigger on 16th armed strobe.
    p0 = m_ptr; n = 0;
    for (int k = 0; k < 400 && !frame_valid; k++) begin
      cycle(1, 1, 8'd10, 8'd128, 1'b0);
      n++;
    end
    chk("t3_valid", frame_valid, 1);
    chk("t3_found", trig_found, 0);
    chk("t3_strobes", n, PRE_TRIG + AUTO_TO + DEPTH - PRE_TRIG - 1);
    chk("t3_base", frame_base, (p0 + PRE_TRIG + AUTO_TO - 1 - PRE_TRIG) % DEPTH);
    rearm();

    // One-cycle reset while ARMED, then crossings during pre-fill.
    repeat (PRE_TRIG + 5) cycle(1, 1, 8'd10, 8'd128, 1'b0);
    cycle(0, 1, 8'd10, 8'd128, 1'b0);
    chk("t6_rst_wr_en", ram_wr_en, 0);
    chk("t6_rst_addr", ram_wr_addr, 0);
    chk("t6_rst_data", ram_wr_data, 0);
    chk("t6_rst_base", frame_base, 0);
    chk("t6_rst_valid", frame_valid, 0);
    chk("t6_rst_found", trig_found, 0);
    n = 0;
    for (int k = 0; k < 400 && !frame_valid; k++) begin
      cycle(1, 1, (n % 2 == 1) ? 8'd255 : 8'd0, 8'd128, 1'b0);
      if (n == 0) chk("t6_first_addr", ram_wr_addr, 0);
      n++;
    end
    chk("t6_valid", frame_valid, 1);
    chk("t6_strobes", n, PRE_TRIG + 1 + DEPTH - PRE_TRIG);
    chk("t6_found", trig_found, 1);

    // Random traffic against the reference model.
    x = 8'd128; lvl = 8'd128; edg = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) lvl = 8'($urandom);
      if ($urandom_range(0, 99) == 0) edg = ~edg;
      if ($urandom_range(0, 15) == 0) wr_over = ~wr_over;
      x = x + 8'($urandom_range(0, 40)) - 8'd20;
      cycle(($urandom_range(0, 1499) != 0), ($urandom_range(0, 3) != 0), x, lvl, edg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
